// File: rtl/mem_req_master.sv
// Single-word read/write initiator for the SoC memory request/ack port.
// Optional ack timeout is compiled in with MEM_REQ_MASTER_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | ready for an upstream command
// WR_REQ | wr_o asserted, waiting for ack_wr_i
// RD_REQ | rd_o asserted, waiting for ack_rd_i
// RSP    | read response held until rsp_ready_i
module mem_req_master #(
    parameter int WORD_WIDTH     = 4,
    parameter int INDEX_WIDTH    = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                   clk_i,
    input  logic                   arstn_i,
    input  logic                   cmd_valid_i,
    output logic                   cmd_ready_o,
    input  logic                   cmd_we_i,
    input  logic [INDEX_WIDTH-1:0] cmd_index_i,
    input  logic [WORD_WIDTH-1:0]  cmd_wdata_i,
    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic [WORD_WIDTH-1:0]  rsp_data_o,
    output logic                   rsp_err_o,
    output logic                   err_o,
    output logic                   wr_o,
    input  logic                   ack_wr_i,
    output logic [WORD_WIDTH-1:0]  wr_data_o,
    output logic [INDEX_WIDTH-1:0] wr_index_o,
    output logic                   rd_o,
    input  logic                   ack_rd_i,
    input  logic [WORD_WIDTH-1:0]  rd_data_i,
    output logic [INDEX_WIDTH-1:0] rd_index_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WR_REQ = 2'd1,
        RD_REQ = 2'd2,
        RSP    = 2'd3
    } state_t;

    // A non-positive limit would make the timeout fire before any request is seen.
    if (TIMEOUT_CYCLES < 1) begin : g_timeout_cycles_invalid
    end

    state_t                 state_q, state_d;
    logic                   cmd_ready_q, cmd_ready_d;
    logic                   wr_q, wr_d;
    logic                   rd_q, rd_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic [WORD_WIDTH-1:0]  rsp_data_q, rsp_data_d;
    logic [WORD_WIDTH-1:0]  wr_data_q, wr_data_d;
    logic [INDEX_WIDTH-1:0] wr_index_q, wr_index_d;
    logic [INDEX_WIDTH-1:0] rd_index_q, rd_index_d;
    logic                   accept;

`ifdef MEM_REQ_MASTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_hit;
    logic             err_q, err_d;
    logic             rsp_err_q, rsp_err_d;

    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES));
`endif

    // cmd_ready_q is only ever set while heading into IDLE, so it doubles as the IDLE decode.
    assign accept = cmd_ready_q & cmd_valid_i;

    always_comb begin
        state_d     = state_q;
        cmd_ready_d = 1'b0;
        wr_d        = 1'b0;
        rd_d        = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        wr_data_d   = wr_data_q;
        wr_index_d  = wr_index_q;
        rd_index_d  = rd_index_q;
`ifdef MEM_REQ_MASTER_TIMEOUT_EN
        cnt_d       = cnt_q;
        err_d       = 1'b0;
        rsp_err_d   = rsp_err_q;
`endif
        case (state_q)
            IDLE: begin
                cmd_ready_d = 1'b1;
                if (accept) begin
                    cmd_ready_d = 1'b0;
`ifdef MEM_REQ_MASTER_TIMEOUT_EN
                    cnt_d       = '0;
`endif
                    if (cmd_we_i) begin
                        state_d    = WR_REQ;
                        wr_d       = 1'b1;
                        wr_index_d = cmd_index_i;
                        wr_data_d  = cmd_wdata_i;
                    end else begin
                        state_d    = RD_REQ;
                        rd_d       = 1'b1;
                        rd_index_d = cmd_index_i;
                    end
                end
            end
            WR_REQ: begin
                if (ack_wr_i) begin
                    state_d     = IDLE;
                    cmd_ready_d = 1'b1;
`ifdef MEM_REQ_MASTER_TIMEOUT_EN
                end else if (timeout_hit) begin
                    state_d     = IDLE;
                    cmd_ready_d = 1'b1;
                    err_d       = 1'b1;
                end else begin
                    wr_d  = 1'b1;
                    cnt_d = cnt_q + CNT_W'(1);
                end
`else
                end else begin
                    wr_d = 1'b1;
                end
`endif
            end
            RD_REQ: begin
                if (ack_rd_i) begin
                    state_d     = RSP;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = rd_data_i;
`ifdef MEM_REQ_MASTER_TIMEOUT_EN
                    rsp_err_d   = 1'b0;
                end else if (timeout_hit) begin
                    state_d     = RSP;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = '0;
                    rsp_err_d   = 1'b1;
                    err_d       = 1'b1;
                end else begin
                    rd_d  = 1'b1;
                    cnt_d = cnt_q + CNT_W'(1);
                end
`else
                end else begin
                    rd_d = 1'b1;
                end
`endif
            end
            RSP: begin
                if (rsp_ready_i) begin
                    state_d     = IDLE;
                    cmd_ready_d = 1'b1;
`ifdef MEM_REQ_MASTER_TIMEOUT_EN
                    rsp_err_d   = 1'b0;
`endif
                end else begin
                    rsp_valid_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!arstn_i) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b0;
            wr_q        <= 1'b0;
            rd_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            wr_data_q   <= '0;
            wr_index_q  <= '0;
            rd_index_q  <= '0;
`ifdef MEM_REQ_MASTER_TIMEOUT_EN
            cnt_q       <= '0;
            err_q       <= 1'b0;
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            wr_data_q   <= wr_data_d;
            wr_index_q  <= wr_index_d;
            rd_index_q  <= rd_index_d;
`ifdef MEM_REQ_MASTER_TIMEOUT_EN
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            rsp_err_q   <= rsp_err_d;
`endif
        end
    end

    assign cmd_ready_o = cmd_ready_q;
    assign wr_o        = wr_q;
    assign rd_o        = rd_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign wr_data_o   = wr_data_q;
    assign wr_index_o  = wr_index_q;
    assign rd_index_o  = rd_index_q;

`ifdef MEM_REQ_MASTER_TIMEOUT_EN
    assign err_o     = err_q;
    assign rsp_err_o = rsp_err_q;
`else
    assign err_o     = 1'b0;
    assign rsp_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_mem_req_master.sv
// Self-checking bench for mem_req_master: directed vector table, reset/corner
// sequences and random traffic against a transaction-level memory model.
module tb_mem_req_master;

    localparam int WW = 4;
    localparam int IW = 4;
    localparam int TO = 16;

    logic          clk_i       = 1'b0;
    logic          arstn_i     = 1'b0;
    logic          cmd_valid_i = 1'b0;
    logic          cmd_we_i    = 1'b0;
    logic [IW-1:0] cmd_index_i = '0;
    logic [WW-1:0] cmd_wdata_i = '0;
    logic          rsp_ready_i = 1'b0;
    logic          ack_wr_i    = 1'b0;
    logic          ack_rd_i    = 1'b0;
    logic [WW-1:0] rd_data_i   = '0;
    logic          cmd_ready_o;
    logic          rsp_valid_o;
    logic [WW-1:0] rsp_data_o;
    logic          rsp_err_o;
    logic          err_o;
    logic          wr_o;
    logic [WW-1:0] wr_data_o;
    logic [IW-1:0] wr_index_o;
    logic          rd_o;
    logic [IW-1:0] rd_index_o;

    mem_req_master #(
        .WORD_WIDTH    (WW),
        .INDEX_WIDTH   (IW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i      (clk_i),
        .arstn_i    (arstn_i),
        .cmd_valid_i(cmd_valid_i),
        .cmd_ready_o(cmd_ready_o),
        .cmd_we_i   (cmd_we_i),
        .cmd_index_i(cmd_index_i),
        .cmd_wdata_i(cmd_wdata_i),
        .rsp_valid_o(rsp_valid_o),
        .rsp_ready_i(rsp_ready_i),
        .rsp_data_o (rsp_data_o),
        .rsp_err_o  (rsp_err_o),
        .err_o      (err_o),
        .wr_o       (wr_o),
        .ack_wr_i   (ack_wr_i),
        .wr_data_o  (wr_data_o),
        .wr_index_o (wr_index_o),
        .rd_o       (rd_o),
        .ack_rd_i   (ack_rd_i),
        .rd_data_i  (rd_data_i),
        .rd_index_o (rd_index_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic          we;
        logic [IW-1:0] idx;
        logic [WW-1:0] wdata;
        int            ack_dly;
        int            rsp_hold;
        logic [WW-1:0] rdata;
        int            exp_cycles;
        logic [WW-1:0] exp_rsp;
    } vec_t;

    int            checks   = 0;
    int            failures = 0;
    vec_t          vecs[7];
    logic [WW-1:0] mem_dut[16];
    logic [WW-1:0] ref_mem[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            ack_wr_i  = 1'($urandom_range(0, 1));
            ack_rd_i  = 1'($urandom_range(0, 1));
            rd_data_i = WW'($urandom);
            tick();
            ack_wr_i = 1'b0;
            ack_rd_i = 1'b0;
            chk("idle_wr", 32'(wr_o), 0);
            chk("idle_rd", 32'(rd_o), 0);
            chk("idle_rsp_valid", 32'(rsp_valid_o), 0);
            chk("idle_cmd_ready", 32'(cmd_ready_o), 1);
        end
    endtask

    // One command end to end; junk commands stay valid while busy and stray acks are injected.
    task automatic run_txn(input logic we, input logic [IW-1:0] idx, input logic [WW-1:0] wdata,
                           input int ack_dly, input int rsp_hold, input logic use_mem,
                           input logic [WW-1:0] rdata, input int exp_cycles,
                           input logic [WW-1:0] exp_rsp);
        int   n;
        logic done;
        n = 0;
        while (cmd_ready_o !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("cmd_ready_before_cmd", 32'(cmd_ready_o), 1);
        cmd_valid_i = 1'b1;
        cmd_we_i    = we;
        cmd_index_i = idx;
        cmd_wdata_i = wdata;
        tick();
        cmd_we_i    = 1'($urandom_range(0, 1));
        cmd_index_i = IW'($urandom);
        cmd_wdata_i = WW'($urandom);
        n    = 0;
        done = 1'b0;
        while (!done && n < 64) begin
            if (we) begin
                chk("wr_req_high", 32'(wr_o), 1);
                chk("wr_rd_exclusive", 32'(rd_o), 0);
                chk("wr_index", 32'(wr_index_o), 32'(idx));
                chk("wr_data", 32'(wr_data_o), 32'(wdata));
            end else begin
                chk("rd_req_high", 32'(rd_o), 1);
                chk("rd_wr_exclusive", 32'(wr_o), 0);
                chk("rd_index", 32'(rd_index_o), 32'(idx));
            end
            chk("busy_cmd_ready", 32'(cmd_ready_o), 0);
            chk("busy_rsp_valid", 32'(rsp_valid_o), 0);
            n++;
            if (we) begin
                ack_rd_i = 1'($urandom_range(0, 1));
                if (n == ack_dly + 1) begin
                    ack_wr_i = 1'b1;
                    if (use_mem) mem_dut[wr_index_o] = wr_data_o;
                end
            end else begin
                ack_wr_i  = 1'($urandom_range(0, 1));
                rd_data_i = WW'($urandom);
                if (n == ack_dly + 1) begin
                    ack_rd_i  = 1'b1;
                    rd_data_i = use_mem ? mem_dut[rd_index_o] : rdata;
                end
            end
            tick();
            ack_wr_i = 1'b0;
            ack_rd_i = 1'b0;
            done = !(wr_o || rd_o);
        end
        chk("req_cycles", 32'(n), 32'(exp_cycles));
        if (we) begin
            cmd_valid_i = 1'b0;
            chk("wr_done_cmd_ready", 32'(cmd_ready_o), 1);
            chk("wr_done_rsp_valid", 32'(rsp_valid_o), 0);
        end else begin
            chk("rsp_valid", 32'(rsp_valid_o), 1);
            chk("rsp_data", 32'(rsp_data_o), 32'(exp_rsp));
            chk("rsp_err", 32'(rsp_err_o), 0);
            chk("rsp_cmd_ready", 32'(cmd_ready_o), 0);
            for (int k = 0; k < rsp_hold; k++) begin
                ack_rd_i  = 1'($urandom_range(0, 1));
                ack_wr_i  = 1'($urandom_range(0, 1));
                rd_data_i = WW'($urandom);
                tick();
                ack_rd_i = 1'b0;
                ack_wr_i = 1'b0;
                chk("hold_rsp_valid", 32'(rsp_valid_o), 1);
                chk("hold_rsp_data", 32'(rsp_data_o), 32'(exp_rsp));
                chk("hold_cmd_ready", 32'(cmd_ready_o), 0);
                chk("hold_no_req", 32'(wr_o | rd_o), 0);
            end
            rsp_ready_i = 1'b1;
            tick();
            rsp_ready_i = 1'b0;
            cmd_valid_i = 1'b0;
            chk("rsp_taken_valid", 32'(rsp_valid_o), 0);
            chk("rsp_taken_cmd_ready", 32'(cmd_ready_o), 1);
            chk("rsp_taken_no_req", 32'(wr_o | rd_o), 0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int errs;
        logic          we;
        logic [IW-1:0] idx;
        logic [WW-1:0] wd;
        int            dly;

        // Reset with a command pending: nothing may be accepted.
        cmd_valid_i = 1'b1;
        cmd_we_i    = 1'b1;
        cmd_index_i = 4'h3;
        cmd_wdata_i = 4'hA;
        tick();
        tick();
        chk("rst_cmd_ready", 32'(cmd_ready_o), 0);
        chk("rst_wr", 32'(wr_o), 0);
        chk("rst_rd", 32'(rd_o), 0);
        chk("rst_rsp_valid", 32'(rsp_valid_o), 0);
        chk("rst_rsp_err", 32'(rsp_err_o), 0);
        chk("rst_err", 32'(err_o), 0);
        chk("rst_rsp_data", 32'(rsp_data_o), 0);
        chk("rst_wr_data", 32'(wr_data_o), 0);
        chk("rst_wr_index", 32'(wr_index_o), 0);
        chk("rst_rd_index", 32'(rd_index_o), 0);
        arstn_i = 1'b1;
        tick();
        chk("post_rst_cmd_ready", 32'(cmd_ready_o), 1);
        chk("post_rst_no_req", 32'(wr_o | rd_o), 0);
        cmd_valid_i = 1'b0;
        idle(2);

        vecs[0] = '{1'b1, 4'h1, 4'h5, 0, 0, 4'h0, 1, 4'h0};
        vecs[1] = '{1'b0, 4'h1, 4'h0, 0, 0, 4'h5, 1, 4'h5};
        vecs[2] = '{1'b0, 4'h2, 4'h0, 3, 0, 4'h7, 4, 4'h7};
        vecs[3] = '{1'b0, 4'h9, 4'h0, 1, 5, 4'hA, 2, 4'hA};
        vecs[4] = '{1'b1, 4'hF, 4'hC, 2, 0, 4'h0, 3, 4'h0};
        vecs[5] = '{1'b0, 4'h0, 4'h0, 0, 2, 4'hF, 1, 4'hF};
        vecs[6] = '{1'b1, 4'h0, 4'h0, 5, 0, 4'h0, 6, 4'h0};
        for (int i = 0; i < 7; i++) begin
            run_txn(vecs[i].we, vecs[i].idx, vecs[i].wdata, vecs[i].ack_dly, vecs[i].rsp_hold,
                    1'b0, vecs[i].rdata, vecs[i].exp_cycles, vecs[i].exp_rsp);
            idle(1);
        end

        // Reset during a read request.
        cmd_valid_i = 1'b1;
        cmd_we_i    = 1'b0;
        cmd_index_i = 4'h3;
        tick();
        cmd_valid_i = 1'b0;
        chk("midrst_rd_started", 32'(rd_o), 1);
        arstn_i = 1'b0;
        tick();
        chk("midrst_rd_dropped", 32'(rd_o), 0);
        chk("midrst_no_rsp", 32'(rsp_valid_o), 0);
        chk("midrst_no_err", 32'(err_o), 0);
        arstn_i = 1'b1;
        tick();
        chk("midrst_ready", 32'(cmd_ready_o), 1);

        // Reset while a response is pending.
        cmd_valid_i = 1'b1;
        tick();
        cmd_valid_i = 1'b0;
        ack_rd_i    = 1'b1;
        rd_data_i   = 4'h9;
        tick();
        ack_rd_i = 1'b0;
        chk("pend_rsp_valid", 32'(rsp_valid_o), 1);
        chk("pend_rsp_data", 32'(rsp_data_o), 9);
        arstn_i = 1'b0;
        tick();
        chk("pend_rsp_discarded", 32'(rsp_valid_o), 0);
        chk("pend_rsp_data_cleared", 32'(rsp_data_o), 0);
        arstn_i = 1'b1;
        tick();
        chk("pend_ready", 32'(cmd_ready_o), 1);
        chk("pend_still_no_rsp", 32'(rsp_valid_o), 0);

        // Random traffic: reads must return the last value the upstream wrote to that index.
        for (int i = 0; i < 16; i++) begin
            ref_mem[i] = WW'($urandom);
            mem_dut[i] = ref_mem[i];
        end
        for (int t = 0; t < 60; t++) begin
            we  = 1'($urandom_range(0, 1));
            idx = IW'($urandom);
            wd  = WW'($urandom);
            dly = int'($urandom_range(0, 4));
            run_txn(we, idx, wd, dly, int'($urandom_range(0, 3)), 1'b1, 4'h0, dly + 1, ref_mem[idx]);
            if (we) ref_mem[idx] = wd;
            idle(int'($urandom_range(0, 2)));
        end

`ifdef MEM_REQ_MASTER_TIMEOUT_EN
        // Counter reaches TO in the (TO+1)th request cycle, so rd_o lasts TO+1 cycles.
        cmd_valid_i = 1'b1;
        cmd_we_i    = 1'b0;
        cmd_index_i = 4'h6;
        tick();
        cmd_valid_i = 1'b0;
        n    = 0;
        errs = 0;
        while (rd_o && n < 60) begin
            n++;
            if (err_o) errs++;
            tick();
        end
        chk("to_rd_cycles", 32'(n), 32'(TO + 1));
        chk("to_no_early_err", 32'(errs), 0);
        chk("to_err_pulse", 32'(err_o), 1);
        chk("to_rsp_valid", 32'(rsp_valid_o), 1);
        chk("to_rsp_err", 32'(rsp_err_o), 1);
        chk("to_rsp_data", 32'(rsp_data_o), 0);
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;
        chk("to_err_single", 32'(err_o), 0);
        chk("to_ready", 32'(cmd_ready_o), 1);
`else
        cmd_valid_i = 1'b1;
        cmd_we_i    = 1'b0;
        cmd_index_i = 4'h6;
        tick();
        cmd_valid_i = 1'b0;
        errs = 0;
        for (int k = 0; k < 100; k++) begin
            if (err_o) errs++;
            tick();
        end
        chk("noto_rd_still_high", 32'(rd_o), 1);
        chk("noto_no_err", 32'(errs), 0);
        chk("noto_no_rsp", 32'(rsp_valid_o), 0);
        arstn_i = 1'b0;
        tick();
        arstn_i = 1'b1;
        tick();
        chk("noto_recover_ready", 32'(cmd_ready_o), 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
